// File: rtl/prio_irq_encoder.sv
// N-line active-low interrupt priority encoder: pending latch, mask, valid/ack grant, cascade ei_n/gs_n/eo_n.
// Grant 2 edges after a request; held until ack. Define PRIO_IRQ_ROUND_ROBIN_EN for rotating priority.
module prio_irq_encoder #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int EDGE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_n,
  input  logic         ei_n,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         irq_valid,
  output logic [W-1:0] irq_id,
  output logic         gs_n,
  output logic         eo_n,
  output logic [N-1:0] pending
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] req_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] set_v, clr_v, elig;
  logic [W-1:0] irq_id_q, irq_id_d, sel;
  logic         irq_valid_q, irq_valid_d;
  logic         gs_n_q, gs_n_d, eo_n_q, eo_n_d;
  logic         grant_ack;

  assign grant_ack = (state_q == PRESENT) && ack;

  always_comb begin
    set_v = (EDGE != 0) ? (req_q & ~req_n) : ~req_n;
    clr_v = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_ack && (irq_id_q == W'(i))) clr_v[i] = 1'b1;
    end
    // A new capture on the acknowledged line survives the clear
    pending_d = set_v | (pending_q & ~clr_v);
    elig      = ei_n ? '0 : (pending_q & ~mask);
    gs_n_d    = ~(|elig);
    eo_n_d    = ei_n | (|elig);
  end

`ifdef PRIO_IRQ_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Walk from the far end of the wrap order so the pointer position wins last
  always_comb begin
    int idx;
    sel = '0;
    idx = 0;
    for (int o = N - 1; o >= 0; o--) begin
      idx = int'(ptr_q) - o;
      if (idx < 0) idx = idx + N;
      if (elig[idx]) sel = W'(idx);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_ack) ptr_d = (irq_id_q == '0) ? W'(N - 1) : (irq_id_q - W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) sel = W'(i);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          irq_valid_d = 1'b1;
          irq_id_d    = sel;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '1;
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      gs_n_q      <= 1'b1;
      eo_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_n;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      gs_n_q      <= gs_n_d;
      eo_n_q      <= eo_n_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign gs_n      = gs_n_q;
  assign eo_n      = eo_n_q;
  assign pending   = pending_q;

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, clocked successor to the 8-to-3 active-low priority encoder.
- Latches N active-low request lines into pending bits, with falling-edge or level capture. Applies a per-line mask.
- Presents the highest-priority eligible index on a valid/ack handshake.
- Keeps cascade-style ei_n/gs_n/eo_n signals, so encoders can be chained as an interrupt front-end for the CPU datapath.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, 3, index width; requires 2**W >= N.
- EDGE, 1, 1 = latch on falling edge of req_n[i]; 0 = level (latch whenever req_n[i] sampled low).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_n  input  N  request lines, active-low; index N-1 is highest fixed priority.
- ei_n  input  1  enable in, active-low; 1 suppresses new grants.
- mask  input  N  1 = line masked from grant; it still accumulates pending.
- ack  input  1  consumer accepts the presented irq_id.
- irq_valid  output  1  grant presented.
- irq_id  output  W  index of the presented grant.
- gs_n  output  1  group select, active-low: some line is eligible.
- eo_n  output  1  enable out, active-low: enabled and nothing eligible (feeds the next lower encoder's ei_n).
- pending  output  N  latched request bits.

Behaviour:
- Reset (async, rst_n=0):
  - irq_valid=0, irq_id=0, gs_n=1, eo_n=1, pending=0.
  - Internal req_q = all ones; state = IDLE; rotate pointer = N-1.
- Sampling:
  - req_q <= req_n on every clk.
  - EDGE=1: set_i = req_q[i] & ~req_n[i].
  - EDGE=0: set_i = ~req_n[i].
  - pending[i] <= set_i | (pending[i] & ~clr_i), so set wins over clear on the same bit and cycle.
- Eligibility (combinational): elig = ei_n ? 0 : (pending & ~mask).
- Priority: sel = highest index with elig[i]=1 (fixed order N-1 down to 0).
- State IDLE:
  - If elig != 0, then at the next edge: irq_valid<=1, irq_id<=sel, state<=PRESENT.
  - ack is ignored in IDLE.
- State PRESENT:
  - irq_id and irq_valid are held stable until ack=1.
  - On ack: clr_i is asserted for i=irq_id; irq_valid<=0; state<=IDLE.
  - There is always at least one IDLE cycle between grants.
- No retraction: while PRESENT, a later mask of irq_id, ei_n rising, or a higher request does not change irq_valid or irq_id.
- Latency: req_n low at edge k sets pending at edge k+1. With elig nonzero after that edge, irq_valid rises at edge k+2.
- Cascade signals (registered each cycle):
  - gs_n <= ~|elig.
  - eo_n <= ei_n | (|elig).
- Width rule: irq_id is zero-extended; indices >= N never appear.
- Reset asserted mid-PRESENT aborts immediately to reset values; no ack is required.

Optional Feature:
- Macro: PRIO_IRQ_ROUND_ROBIN_EN.
- Defined:
  - Priority search starts at the rotate pointer and descends with wrap (ptr, ptr-1, ..., 0, N-1, ...).
  - On each ack of index j, ptr <= (j==0) ? N-1 : j-1.
  - The pointer resets to N-1, so the first grant matches fixed order.
- Undefined: fixed priority N-1 highest; no pointer register exists.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> irq_valid=0, irq_id=0, gs_n=1, eo_n=1, pending=0; release -> unchanged until a request arrives.
- EDGE=1, one-cycle low pulse on req_n[5] at edge k -> pending=8'h20 at k+1, irq_valid=1 and irq_id=5 at k+2. Ack one cycle -> irq_valid=0, pending=0 on the next edge.
- req_n[2] and req_n[6] pulsed together -> irq_id=6 first. After ack, one IDLE cycle, then irq_id=2. After the second ack, pending=0.
- mask=8'h40 with lines 2 and 6 pending -> irq_id=2, and pending[6] stays 1. Clear mask -> irq_id=6 is granted after the ack of 2.
- ei_n=1 with pending=8'h08 -> irq_valid stays 0, gs_n=1, eo_n=1. ei_n=0 with pending=0 -> eo_n=0, gs_n=1. Ack while PRESENT and a new set on the same bit in the same cycle -> pending bit stays 1.
- With PRIO_IRQ_ROUND_ROBIN_EN, lines 7 and 3 held low (EDGE=0) -> grants alternate 7, 3, 7, 3. Without the macro -> 7 is granted every time.
